serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder controller. Sequences a single one-bit full-adder cell over two WIDTH-bit operands, LSB first, one bit per clock, with a registered carry loop. Presents a start/busy/done handshake to the surrounding datapath. Trades WIDTH cycles of latency for one adder cell in area-constrained arithmetic paths.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_ctrl_if.sv | 40 ++++
 rtl/one_bit_full_adder_v.sv | 13 +
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// Optional subtract mode is enabled with SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done bundle between datapath and serial adder.
// The sub signal exists only with SERIAL_ADDER_SUB_EN.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/one_bit_full_adder_v.sv
// Single-bit full adder cell reused by the serial adder.
module one_bit_full_adder_v (
  input  logic A0,
  input  logic B0,
  input  logic Ci,
  output logic S,
  output logic C
);

  assign S = A0 ^ B0 ^ Ci;
  assign C = (A0 & B0) | (A0 & Ci) | (B0 & Ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the a-b subtract mode.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_MSB = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             cell_s, cell_c;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  one_bit_full_adder_v u_fa (
    .A0 (a_q[0]),
    .B0 (b_q[0]),
    .Ci (carry_q),
    .S  (cell_s),
    .C  (cell_c)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // a-b computed as a + ~b + 1
  assign b_ld = bus.sub ? ~bus.b : bus.b;
  assign c_ld = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_ld = bus.b;
  assign c_ld = bus.cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_ld;
          carry_d = c_ld;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        carry_d = cell_c;
        if (cnt_q == CNT_PRE) cmsb_d = cell_c;
        // counter parks at the MSB index instead of wrapping
        if (cnt_q == CNT_MSB) begin
          cout_d  = cell_c;
          ovf_d   = cmsb_q ^ cell_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t sb[$];

  serial_adder_ctrl_if #(.WIDTH(W)) ifc ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(ifc.sum), 32'(e.sum));
        chk("cout", 32'(ifc.cout), 32'(e.cout));
        chk("ovf", 32'(ifc.ovf), 32'(e.ovf));
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic set_in(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
    ifc.a   = a;
    ifc.b   = b;
    ifc.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    ifc.sub = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ifc.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy stuck expected idle");
    end
  endtask

  task automatic push(input logic [7:0] s, input logic c, input logic o,
                      input int due);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec,
                        input logic eo);
    wait_idle();
    set_in(a, b, cin, sub);
    ifc.start = 1'b1;
    push(es, ec, eo, cyc + 1 + W);
    @(negedge clk);
    ifc.start = 1'b0;
    chk("busy_after_accept", 32'(ifc.busy), 32'd1);
    wait_idle();
    chk("sum_hold", 32'(ifc.sum), 32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    ifc.start = 1'b0;
    set_in(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_sum", 32'(ifc.sum), 32'd0);
    chk("rst_cout", 32'(ifc.cout), 32'd0);
    chk("rst_ovf", 32'(ifc.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
    run_op(8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op(8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // ignored start and operand changes mid-operation
    wait_idle();
    set_in(8'h12, 8'h34, 1'b0, 1'b0);
    ifc.start = 1'b1;
    push(8'h46, 1'b0, 1'b0, cyc + 1 + W);
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    set_in(8'hFF, 8'hFF, 1'b1, 1'b0);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_start_busy", 32'(ifc.busy), 32'd0);
    chk("ignored_start_sum", 32'(ifc.sum), 32'h46);

    // start held high: operations every W+2 cycles
    set_in(8'h10, 8'h20, 1'b0, 1'b0);
    ifc.start = 1'b1;
    base = cyc + 1;
    push(8'h30, 1'b0, 1'b0, base + W);
    push(8'h30, 1'b0, 1'b0, base + W + 10);
    push(8'h30, 1'b0, 1'b0, base + W + 20);
    n = done_cnt + 3;
    for (int k = 0; k < 60 && done_cnt < n; k++) @(negedge clk);
    ifc.start = 1'b0;
    chk("held_start_dones", 32'(done_cnt), 32'(n));
    wait_idle();

    // reset mid-shift at cnt=3
    set_in(8'h3C, 8'h05, 1'b0, 1'b0);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_done", 32'(ifc.done), 32'd0);
    chk("abort_sum", 32'(ifc.sum), 32'd0);
    chk("abort_cout", 32'(ifc.cout), 32'd0);
    chk("abort_ovf", 32'(ifc.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle", 32'(ifc.busy), 32'd0);
    run_op(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op(8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
